// File: rtl/tnn_popcount_neuron_seq.sv
// Sequential ternary neuron: per-beat popcount(pos)-popcount(neg) over N lanes,
// accumulated across BEATS beats, with a thresholded ternary activation.
module tnn_popcount_neuron_seq #(
  parameter int N = 23,
  parameter int BEATS = 4,
  parameter int ACC_W = 8,
  parameter logic [N-1:0] LANE_MASK = {N{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_pos,
  input  logic [N-1:0]     in_neg,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [1:0]       out_act
);

  localparam int D_W   = $clog2(N + 1) + 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // The accumulator has to hold the largest possible sum of either sign.
  if (N * BEATS > (2 ** (ACC_W - 1)) - 1) begin : g_acc_width_check
    $error("ACC_W too narrow for +-N*BEATS");
  end

  function automatic logic [D_W-1:0] popcount(input logic [N-1:0] v);
    logic [D_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + D_W'(v[i]);
    return c;
  endfunction

  logic [N-1:0]            lane_p;
  logic [N-1:0]            lane_m;
  logic signed [D_W-1:0]   beat_d;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    is_first;
  logic                    is_last;
  logic                    accept;
  logic                    out_fire;
  logic                    pending;
  logic                    pending_next;

  logic                    s1_valid;
  logic signed [D_W-1:0]   s1_d;
  logic                    s1_first;
  logic                    s1_last;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] thr_reg;
  logic signed [ACC_W-1:0] d_ext;
  logic signed [ACC_W-1:0] sum_next;
  logic [1:0]              act_next;

  // A lane carrying both +1 and -1 contributes nothing.
  assign lane_p = in_pos & ~in_neg & LANE_MASK;
  assign lane_m = in_neg & ~in_pos & LANE_MASK;
  assign beat_d = $signed(popcount(lane_p)) - $signed(popcount(lane_m));

  assign is_first = (beat_cnt == '0);
  assign is_last  = (beat_cnt == CNT_W'(BEATS - 1));
  assign accept   = in_valid & in_ready & ~clear;
  assign out_fire = out_valid & out_ready;

  assign d_ext    = ACC_W'(s1_d);
  assign sum_next = (s1_first ? '0 : acc) + d_ext;

  always_comb begin
    act_next = 2'b00;
    if (sum_next > thr_reg)       act_next = 2'b01;
    else if (sum_next < -thr_reg) act_next = 2'b11;
  end

  // A result is pending from acceptance of the final beat until it is consumed.
  always_comb begin
    pending_next = pending;
    if (clear)                  pending_next = 1'b0;
    else if (accept && is_last) pending_next = 1'b1;
    else if (out_fire)          pending_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      pending  <= pending_next;
      in_ready <= ~pending_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      thr_reg  <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_d     <= beat_d;
        s1_first <= is_first;
        s1_last  <= is_last;
        beat_cnt <= is_last ? '0 : beat_cnt + 1'b1;
        if (is_first) thr_reg <= thresh;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_act   <= 2'b00;
    end else if (clear) begin
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_fire) out_valid <= 1'b0;
      if (s1_valid) begin
        acc <= sum_next;
        if (s1_last) begin
          out_sum   <= sum_next;
          out_act   <= act_next;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tnn_popcount_neuron_seq.sv
// Directed bench for tnn_popcount_neuron_seq: a full-mask instance and one with
// lanes 0..7 masked share the same stimulus; each is checked against expected values.
module tb_tnn_popcount_neuron_seq;

  localparam int N = 23;
  localparam int BEATS = 4;
  localparam int ACC_W = 8;
  localparam logic [N-1:0] MASK_M = 23'h7FFF00;
  localparam logic [N-1:0] ALL = 23'h7FFFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [N-1:0]     in_pos = '0;
  logic [N-1:0]     in_neg = '0;
  logic [ACC_W-1:0] thresh = '0;
  logic             out_ready = 1'b0;

  logic             in_ready, in_ready_m;
  logic             out_valid, out_valid_m;
  logic [ACC_W-1:0] out_sum, out_sum_m;
  logic [1:0]       out_act, out_act_m;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tnn_popcount_neuron_seq #(.N(N), .BEATS(BEATS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .thresh(thresh), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_act(out_act)
  );

  tnn_popcount_neuron_seq #(.N(N), .BEATS(BEATS), .ACC_W(ACC_W), .LANE_MASK(MASK_M)) dut_m (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_pos(in_pos), .in_neg(in_neg), .thresh(thresh), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_sum(out_sum_m), .out_act(out_act_m)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int beat_val(input logic [N-1:0] p, input logic [N-1:0] n,
                                  input logic [N-1:0] mask);
    return $countones(p & ~n & mask) - $countones(n & ~p & mask);
  endfunction

  function automatic int act_of(input int sum, input int thr);
    if (sum > thr) return 1;
    if (sum < -thr) return 3;
    return 0;
  endfunction

  // Present one beat and hold it until the handshake edge has passed.
  task automatic applyStimulus(input logic [N-1:0] p, input logic [N-1:0] n, input int thr);
    int waited;
    in_pos = p;
    in_neg = n;
    thresh = ACC_W'(thr);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) checkOutput("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic take_result(input int es, input int ea, input int esm, input int eam);
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("out_valid", out_valid, 1);
    checkOutput("out_valid_m", out_valid_m, 1);
    checkOutput("out_sum", int'($signed(out_sum)), es);
    checkOutput("out_act", out_act, ea);
    checkOutput("out_sum_m", int'($signed(out_sum_m)), esm);
    checkOutput("out_act_m", out_act_m, eam);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid_drop", out_valid, 0);
    checkOutput("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int es, esm, thr;
    logic [N-1:0] p, n;

    // Reset state
    #2;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_sum", out_sum, 0);
    checkOutput("rst_out_act", out_act, 0);
    checkOutput("rst_out_valid_m", out_valid_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rdy_after_rst", in_ready, 1);

    // All lanes +1 for four beats, with latency and backpressure checks
    for (int b = 0; b < BEATS; b++) applyStimulus(ALL, '0, 5);
    checkOutput("lat_valid_e0", out_valid, 0);
    checkOutput("lat_rdy_e0", in_ready, 0);
    @(posedge clk); #1;
    checkOutput("lat_valid_e1", out_valid, 1);
    take_result(92, 1, 60, 1);

    // Conflicting lanes cancel; negative sum around the threshold boundary
    for (int b = 0; b < BEATS; b++) applyStimulus(ALL, ALL, 5);
    take_result(0, 0, 0, 0);
    for (int b = 0; b < BEATS; b++) applyStimulus('0, 23'h700000, 11);
    take_result(-12, 3, -12, 3);
    for (int b = 0; b < BEATS; b++) applyStimulus('0, 23'h700000, 12);
    take_result(-12, 0, -12, 0);

    // Output held under backpressure, then a fresh evaluation
    for (int b = 0; b < BEATS; b++) applyStimulus(ALL, '0, 5);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_sum", int'($signed(out_sum)), 92);
    end
    take_result(92, 1, 60, 1);
    for (int b = 0; b < BEATS; b++) applyStimulus(23'h000400, '0, 3);
    take_result(4, 1, 4, 1);

    // Clear wins over a beat presented in the same cycle
    applyStimulus(ALL, '0, 0);
    applyStimulus(ALL, '0, 0);
    in_pos = ALL;
    in_neg = '0;
    in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    checkOutput("clear_rdy", in_ready, 1);
    for (int b = 0; b < BEATS; b++) applyStimulus(23'h000300, '0, 8);
    take_result(8, 0, 8, 0);

    // Random evaluations against the lane model
    for (int e = 0; e < 1000; e++) begin
      thr = int'($urandom_range(0, 30));
      es = 0;
      esm = 0;
      for (int b = 0; b < BEATS; b++) begin
        p = N'($urandom);
        n = N'($urandom);
        es += beat_val(p, n, ALL);
        esm += beat_val(p, n, MASK_M);
        applyStimulus(p, n, thr);
      end
      take_result(es, act_of(es, thr), esm, act_of(esm, thr));
    end

    // Asynchronous reset in the middle of the third beat
    applyStimulus(ALL, '0, 1);
    applyStimulus(ALL, '0, 1);
    in_pos = ALL;
    in_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_rdy", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus('0, 23'h003000, 1);
    applyStimulus(23'h0F0000, '0, 1);
    applyStimulus(23'h000001, 23'h000001, 1);
    applyStimulus(23'h000000, 23'h000080, 1);
    take_result(1, 0, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
